// File: rtl/ys_poly_small_pkg.sv
// ys_poly_small shared definitions.
// Holds the default polynomial and RAM geometry, coefficient widths, the
// sequencer FSM state encoding, and the helpers that derive the beat count
// and the last-beat lane mask from the coefficient count.
package ys_poly_small_pkg;

    localparam int NTRU_N_DEF = 509;
    localparam int AW_DEF     = 7;
    localparam int DW_13      = 13;
    localparam int DW_PH      = 4 * DW_13;   // one RAM word: four coefficients

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_READ  = 2'd1,
        S_DRAIN = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    // Eight coefficients per beat: two RAM words of four coefficients each.
    function automatic int beats_of(input int n);
        return (n + 7) / 8;
    endfunction

    // On the last beat, lane j carries coefficient 8*(beats-1)+j.
    // Only lanes below n hold real coefficients.
    function automatic logic [7:0] last_mask(input int n);
        int valid;
        valid = n - 8 * (beats_of(n) - 1);
        return 8'((1 << valid) - 1);
    endfunction

endpackage

// File: rtl/ys_poly_small_dly.sv
// ys_poly_small_dly: width x depth register shift line with synchronous clear.
// It aligns the read-side controls with the data that ram1 returns.
//   clk  : clock
//   clr  : synchronous clear; every stage is zeroed on the same edge
//   din  : value entering stage 0
//   dout : value leaving the last stage, DEPTH cycles after it entered
module ys_poly_small_dly #(
    parameter int W     = 1,
    parameter int DEPTH = 1
) (
    input  logic         clk,
    input  logic         clr,
    input  logic [W-1:0] din,
    output logic [W-1:0] dout
);

    logic [W-1:0] pipe [DEPTH];

    always_ff @(posedge clk) begin
        if (clr) begin
            for (int i = 0; i < DEPTH; i++) pipe[i] <= '0;
        end else begin
            pipe[0] <= din;
            for (int i = 1; i < DEPTH; i++) pipe[i] <= pipe[i-1];
        end
    end

    assign dout = pipe[DEPTH-1];

endmodule

// File: rtl/ys_poly_small_ctrl.sv
// ys_poly_small_ctrl: sequencer for the ys_poly_small execution datapaths.
// A pass streams the source polynomial out of ram1, two words per beat, with no
// bubbles between beats. It then replays the same addresses as ram2 writes
// RAM_RD_LAT cycles later, so each write lines up with its read data.
// Optional build macro YS_POLY_SMALL_PADMASK_EN: when it is defined, the last
// write beat masks the pad lanes, and ram2_web is dropped if every lane on
// port b is pad. When it is undefined, every write beat is unmasked.
// Ports:
//   clk, rst            : clock, synchronous active-high reset
//   start               : one-cycle start request; accepted only when idle
//   busy, done          : pass in progress / one-cycle completion pulse
//   ram1_ena            : ram1 read enable for both ports
//   ram1_addra/addrb    : even / odd ram1 word address of the current beat
//   ram2_wea/web        : ram2 write enables
//   ram2_addra/addrb    : ram2 write addresses
//   f_ctr               : 0 on the write beat carrying coefficient 0, else 1
//   pad_mask            : lane-valid mask of the current write beat (0 when idle)
//
// state   | meaning
// S_IDLE  | waiting for start
// S_READ  | issuing BEATS back-to-back ram1 reads
// S_DRAIN | waiting RAM_RD_LAT cycles for the last writes to retire
// S_DONE  | one-cycle done pulse
module ys_poly_small_ctrl
    import ys_poly_small_pkg::*;
#(
    parameter int NTRU_N     = NTRU_N_DEF,
    parameter int AW         = AW_DEF,
    parameter int RAM_RD_LAT = 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    output logic          busy,
    output logic          done,
    output logic          ram1_ena,
    output logic [AW-1:0] ram1_addra,
    output logic [AW-1:0] ram1_addrb,
    output logic          ram2_wea,
    output logic          ram2_web,
    output logic [AW-1:0] ram2_addra,
    output logic [AW-1:0] ram2_addrb,
    output logic          f_ctr,
    output logic [7:0]    pad_mask
);

    localparam int BEATS = beats_of(NTRU_N);
    localparam logic [AW-1:0] BEATS_M1 = AW'(BEATS - 1);
    localparam logic [AW-1:0] LAT_M1   = AW'(RAM_RD_LAT - 1);
    localparam int PW = 3 + 8 + 2 * AW;

    if (2 * BEATS > (1 << AW)) begin : g_aw_too_small
        $fatal(1, "ys_poly_small_ctrl: AW too narrow for 2*BEATS word addresses");
    end
    if (RAM_RD_LAT < 1 || RAM_RD_LAT > 3) begin : g_lat_range
        $fatal(1, "ys_poly_small_ctrl: RAM_RD_LAT must be 1..3");
    end

    state_t        state;
    logic [AW-1:0] cnt;      // READ: beats still to issue; DRAIN: cycles still to wait

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= S_IDLE;
            cnt        <= '0;
            busy       <= 1'b0;
            done       <= 1'b0;
            ram1_ena   <= 1'b0;
            ram1_addra <= '0;
            ram1_addrb <= '0;
        end else begin
            done <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (start) begin
                        state      <= S_READ;
                        cnt        <= BEATS_M1;
                        busy       <= 1'b1;
                        ram1_ena   <= 1'b1;
                        ram1_addra <= '0;
                        ram1_addrb <= AW'(1);
                    end
                end
                S_READ: begin
                    if (cnt == '0) begin
                        state      <= S_DRAIN;
                        cnt        <= LAT_M1;
                        ram1_ena   <= 1'b0;
                        ram1_addra <= '0;
                        ram1_addrb <= '0;
                    end else begin
                        cnt        <= cnt - AW'(1);
                        ram1_addra <= ram1_addra + AW'(2);
                        ram1_addrb <= ram1_addrb + AW'(2);
                    end
                end
                S_DRAIN: begin
                    if (cnt == '0) begin
                        state <= S_DONE;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                    end else begin
                        cnt <= cnt - AW'(1);
                    end
                end
                S_DONE: state <= S_IDLE;
                default: state <= S_IDLE;
            endcase
        end
    end

    // The write-side controls are formed on the read side and then delayed.
    // Every ram2 output is therefore a plain register output of the delay line.
    logic          f_rd;
    logic          web_rd;
    logic [7:0]    mask_rd;
    logic [PW-1:0] pipe_out;

    assign f_rd = ram1_ena & (ram1_addra != '0);

`ifdef YS_POLY_SMALL_PADMASK_EN
    localparam logic [AW-1:0] LAST_ADDR = AW'(2 * (BEATS - 1));
    localparam logic [7:0]    LAST_MASK = last_mask(NTRU_N);
    logic rd_last;
    assign rd_last = ram1_ena & (ram1_addra == LAST_ADDR);
    assign mask_rd = !ram1_ena ? 8'h00 : (rd_last ? LAST_MASK : 8'hFF);
    assign web_rd  = ram1_ena & ~(rd_last & (LAST_MASK[7:4] == 4'h0));
`else
    assign mask_rd = ram1_ena ? 8'hFF : 8'h00;
    assign web_rd  = ram1_ena;
`endif

    ys_poly_small_dly #(
        .W     (PW),
        .DEPTH (RAM_RD_LAT)
    ) u_dly (
        .clk  (clk),
        .clr  (rst),
        .din  ({ram1_ena, web_rd, f_rd, mask_rd, ram1_addra, ram1_addrb}),
        .dout (pipe_out)
    );

    assign {ram2_wea, ram2_web, f_ctr, pad_mask, ram2_addra, ram2_addrb} = pipe_out;

endmodule

// File: tb/tb_ys_poly_small_ctrl.sv
module tb_ys_poly_small_ctrl;

    localparam int AW    = 7;
    localparam int N_A   = 509;
    localparam int LAT_A = 1;
    localparam int N_B   = 500;
    localparam int LAT_B = 3;
`ifdef YS_POLY_SMALL_PADMASK_EN
    localparam bit PADMASK = 1'b1;
`else
    localparam bit PADMASK = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic start = 1'b0;
    always #5 clk = ~clk;

    logic          busy_a, done_a, ena_a, wea_a, web_a, f_a;
    logic [AW-1:0] ra_a, rb_a, wa_a, wb_a;
    logic [7:0]    mask_a;
    logic          busy_b, done_b, ena_b, wea_b, web_b, f_b;
    logic [AW-1:0] ra_b, rb_b, wa_b, wb_b;
    logic [7:0]    mask_b;

    ys_poly_small_ctrl #(.NTRU_N(N_A), .AW(AW), .RAM_RD_LAT(LAT_A)) u_a (
        .clk(clk), .rst(rst), .start(start), .busy(busy_a), .done(done_a),
        .ram1_ena(ena_a), .ram1_addra(ra_a), .ram1_addrb(rb_a),
        .ram2_wea(wea_a), .ram2_web(web_a), .ram2_addra(wa_a), .ram2_addrb(wb_a),
        .f_ctr(f_a), .pad_mask(mask_a));

    ys_poly_small_ctrl #(.NTRU_N(N_B), .AW(AW), .RAM_RD_LAT(LAT_B)) u_b (
        .clk(clk), .rst(rst), .start(start), .busy(busy_b), .done(done_b),
        .ram1_ena(ena_b), .ram1_addra(ra_b), .ram1_addrb(rb_b),
        .ram2_wea(wea_b), .ram2_web(web_b), .ram2_addra(wa_b), .ram2_addrb(wb_b),
        .f_ctr(f_b), .pad_mask(mask_b));

    int checks = 0;
    int errors = 0;
    bit chk_en = 1'b0;
    int ta = 0;     // cycle position within a pass of instance a; 0 = idle
    int tb = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h at %0t", nm, act, exp, $time);
        end
    endtask

    // A start sampled in cycle 0 puts the pass at position 1 in cycle 1.
    // The pass ends after the done cycle, position beats+lat+1.
    function automatic int step(input int t, input logic r, input logic s, input int n, input int lat);
        int last_pos;
        last_pos = (n + 7) / 8 + lat + 1;
        if (r) return 0;
        if (t == 0) return s ? 1 : 0;
        if (t >= last_pos) return 0;
        return t + 1;
    endfunction

    always @(posedge clk) begin
        ta = step(ta, rst, start, N_A, LAT_A);
        tb = step(tb, rst, start, N_B, LAT_B);
        if (rst) chk_en = 1'b1;
    end

    task automatic check_inst(input string id, input int t, input int n, input int lat,
                              input logic busy, input logic done, input logic ena,
                              input logic [AW-1:0] ra, input logic [AW-1:0] rb,
                              input logic wea, input logic web,
                              input logic [AW-1:0] wa, input logic [AW-1:0] wb,
                              input logic f, input logic [7:0] mask);
        int   beats, rk, wk;
        bit   rd, wr;
        logic [7:0] em;
        beats = (n + 7) / 8;
        rd = (t >= 1) && (t <= beats);
        wr = (t >= 1 + lat) && (t <= beats + lat);
        rk = t - 1;
        wk = t - 1 - lat;
        em = 8'h00;
        if (wr) begin
            for (int j = 0; j < 8; j++) em[j] = PADMASK ? (8 * wk + j < n) : 1'b1;
        end
        chk({id, "_busy"}, busy, ((t >= 1) && (t <= beats + lat)) ? 1 : 0);
        chk({id, "_done"}, done, (t == beats + lat + 1) ? 1 : 0);
        chk({id, "_ram1_ena"}, ena, rd ? 1 : 0);
        chk({id, "_ram2_wea"}, wea, wr ? 1 : 0);
        chk({id, "_ram2_web"}, web, (wr && (em[7:4] != 4'h0)) ? 1 : 0);
        chk({id, "_f_ctr"}, f, (wr && wk != 0) ? 1 : 0);
        chk({id, "_pad_mask"}, mask, em);
        if (rd) begin
            chk({id, "_ram1_addra"}, ra, 2 * rk);
            chk({id, "_ram1_addrb"}, rb, 2 * rk + 1);
        end
        if (wr) begin
            chk({id, "_ram2_addra"}, wa, 2 * wk);
            chk({id, "_ram2_addrb"}, wb, 2 * wk + 1);
        end
    endtask

    always @(negedge clk) begin
        if (chk_en) begin
            check_inst("a", ta, N_A, LAT_A, busy_a, done_a, ena_a, ra_a, rb_a,
                       wea_a, web_a, wa_a, wb_a, f_a, mask_a);
            check_inst("b", tb, N_B, LAT_B, busy_b, done_b, ena_b, ra_b, rb_b,
                       wea_b, web_b, wa_b, wb_b, f_b, mask_b);
            // Hand-computed timing points, independent of the model above.
            if (ta == 2)  begin chk("pin_a_wr0_wea", wea_a, 1); chk("pin_a_wr0_f", f_a, 0); end
            if (ta == 3)  chk("pin_a_wr1_f", f_a, 1);
            if (ta == 64) chk("pin_a_rd_last_addra", ra_a, 126);
            if (ta == 65) begin
                chk("pin_a_wr_last_addra", wa_a, 126);
                chk("pin_a_last_mask", mask_a, PADMASK ? 8'h1F : 8'hFF);
                chk("pin_a_last_web", web_a, 1);
            end
            if (ta == 66) chk("pin_a_done", done_a, 1);
            if (tb == 4)  begin chk("pin_b_wr0_wea", wea_b, 1); chk("pin_b_wr0_f", f_b, 0); end
            if (tb == 66) begin
                chk("pin_b_busy_end", busy_b, 1);
                chk("pin_b_last_mask", mask_b, PADMASK ? 8'h0F : 8'hFF);
                chk("pin_b_last_web", web_b, PADMASK ? 0 : 1);
            end
            if (tb == 67) chk("pin_b_done", done_b, 1);
        end
    end

    task automatic pass_start();
        @(posedge clk); #1 start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
    endtask

    initial begin
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("rst_busy", busy_a, 0);
        chk("rst_ram1_ena", ena_a, 0);
        chk("rst_ram1_addra", ra_a, 0);
        chk("rst_ram2_addrb", wb_a, 0);
        chk("rst_pad_mask", mask_b, 0);
        chk("rst_done", done_b, 0);

        // Start in cycle 0, extra start in cycle 10 while busy.
        pass_start();
        repeat (9) @(posedge clk);
        #1 start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
        repeat (80) @(posedge clk);

        // Reset in cycle 20 of a pass; no write or done may follow.
        pass_start();
        repeat (19) @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk); #1 rst = 1'b0;
        @(negedge clk);
        chk("midrst_wea", wea_a, 0);
        chk("midrst_busy", busy_b, 0);
        chk("midrst_ena", ena_a, 0);
        repeat (80) @(posedge clk);

        // start coincident with rst: rst wins.
        #1 rst = 1'b1; start = 1'b1;
        @(posedge clk); #1 rst = 1'b0; start = 1'b0;
        @(negedge clk);
        chk("rst_start_busy", busy_a, 0);
        repeat (4) @(posedge clk);

        // Clean full pass after the reset.
        pass_start();
        repeat (80) @(posedge clk);

        // Random starts and occasional resets.
        for (int i = 0; i < 3000; i++) begin
            @(posedge clk);
            #1;
            rst   = ($urandom_range(0, 249) == 0);
            start = ($urandom_range(0, 7) == 0);
        end
        #1 rst = 1'b0; start = 1'b0;
        repeat (80) @(posedge clk);
        @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/ys_poly_small_ctrl.md
Name: ys_poly_small_ctrl

Overview:
Sequencer for the ys_poly_small execution datapaths (for example the mode-3 stage g[i]=3*(g[i-1]-g[i]), g[0]=-3*g[0]). It streams the source polynomial from ram1 two words per cycle (4 x 13-bit coefficients per word, 8 coefficients per beat) and generates the ram2 write addresses and enables, aligned to RAM read latency. It also drives the datapath's first-beat flag f_ctr and a pad-lane mask. It sits directly upstream of the exe datapaths and owns all RAM addressing for the operation.

Parameters:
NTRU_N, 509, number of polynomial coefficients
AW, 7, RAM word-address width
RAM_RD_LAT, 1, ram1 read latency in cycles, 1..3
BEATS, ceil(NTRU_N/8), derived localparam; beats per pass (64 at default)

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
start  in  1  one-cycle start request
busy  out  1  operation in progress
done  out  1  one-cycle completion pulse
ram1_ena  out  1  ram1 read enable, both ports
ram1_addra  out  AW  ram1 port-a word address, even words
ram1_addrb  out  AW  ram1 port-b word address, odd words
ram2_wea  out  1  ram2 port-a write enable
ram2_web  out  1  ram2 port-b write enable
ram2_addra  out  AW  ram2 port-a write address
ram2_addrb  out  AW  ram2 port-b write address
f_ctr  out  1  0 on the beat carrying coefficient 0, 1 on all later beats; aligned with ram1 read data
pad_mask  out  8  per-lane valid mask for the current write beat; lanes 0-3 are port a, lanes 4-7 are port b

Behaviour:
- Clock is clk. Reset is rst, synchronous and active-high. On reset: state=IDLE, and busy, done, ram1_ena, ram2_wea, ram2_web, f_ctr are 0. All addresses are 0 and pad_mask is 8'h00.
- FSM states: IDLE, READ, DRAIN, DONE.
  - IDLE -> READ when start=1.
  - READ runs for exactly BEATS cycles, then goes to DRAIN. If RAM_RD_LAT=0 it would go straight to DONE, but that value is illegal.
  - DRAIN lasts RAM_RD_LAT cycles, then goes to DONE.
  - DONE lasts 1 cycle, then returns to IDLE.
- start is ignored outside IDLE.
- busy=1 in READ and DRAIN. busy=0 in DONE and IDLE. done=1 only in DONE.
- READ beat k (k=0..BEATS-1): ram1_ena=1, ram1_addra=2k, ram1_addrb=2k+1.
- Beats are issued back-to-back with no bubbles. This is mandatory because the datapath carries the previous beat's top coefficient in a free-running register.
- Write side: ram2_wea/web, ram2_addra/addrb, f_ctr and pad_mask come from an RAM_RD_LAT-deep shift pipeline of the read-side controls.
  - Write beat k is asserted exactly RAM_RD_LAT cycles after read beat k, using the same addresses.
  - f_ctr=0 only when write beat 0 is presented. It is 1 for all later beats and returns to 0 once the pass is complete.
- Timing with start sampled in cycle 0:
  - read beat k in cycle 1+k
  - write beat k in cycle 1+k+RAM_RD_LAT
  - done in cycle 1+BEATS+RAM_RD_LAT
- Address widths: 2k+1 must fit AW. Elaboration fails if 2*BEATS > 2^AW.
- Pad handling: the last beat covers coefficients 8(BEATS-1)..8*BEATS-1. Lanes with index >= NTRU_N are pad lanes (3 pad lanes at N=509).
- Reset mid-operation: the FSM returns to IDLE and all pipelined enables are cleared on the same edge. No write may occur after the reset edge, and done is not pulsed.
- start coincident with rst: rst wins.

Optional Feature:
YS_POLY_SMALL_PADMASK_EN.
- Defined: pad_mask = 8'hFF on every write beat except the last, which carries 1s only for lanes < NTRU_N (8'h1F at N=509). ram2_web is suppressed on the last beat if all port-b lanes are pad.
- Undefined: pad_mask = 8'hFF on every write beat, and writes are never suppressed.
- In both cases pad_mask = 8'h00 when no write is active.

Decomposition:
- Shared package/header (param.v / ys_poly_small.vh): NTRU_N, DW_13, DW_PH, AW, BEATS, and the FSM state encoding.
- One natural sub-module: ys_poly_small_dly. This is a parameterised width x depth register shift line with synchronous clear, used for the read-to-write alignment pipeline.

Test Plan:
- Default params, start in cycle 0 -> ram1_addra 0,2,..,126 in cycles 1..64; ram2_wea with the same addresses in cycles 2..65; done=1 only in cycle 66; f_ctr=0 at cycle 2 and 1 in cycles 3..65.
- RAM_RD_LAT=3 -> write beat 0 in cycle 4, done in cycle 68; busy high in cycles 1..67.
- start pulsed again in cycle 10 while busy -> ignored: a single pass only, and addresses are unperturbed.
- rst asserted in cycle 20 -> in cycle 21 all enables are 0, busy=0, and no done pulse follows; a new start afterwards runs a clean full pass.
- YS_POLY_SMALL_PADMASK_EN, N=509 -> last write beat pad_mask=8'h1F with ram2_web=1; N=500 -> pad_mask=8'h0F and ram2_web=0 on the last beat.
- End-to-end with the mode-3 datapath and a golden model over random coefficients in [-1,1] -> ram2 matches 3*(g[i-1]-g[i]) mod 2^13 and g[0]=-3*g[0].
